// File: rtl/key_event_pkg.sv
// Shared types and helpers for the multi-key event front end.
package key_event_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } key_state_t;

    // Width able to hold the value itself; never below one bit.
    function automatic int cnt_width(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/key_event_channel.sv
// One key channel: 2-FF synchroniser, debounce, press/hold/repeat classifier.
// state  | meaning
// S_IDLE | debounced key released
// S_HELD | pressed, long-press point not yet reached
// S_LONG | long press reached, auto-repeat period running
module key_event_channel
    import key_event_pkg::*;
#(
    parameter int DEB_CYCLES    = 120000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2400000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long,
    output logic o_repeat
);

    localparam int DEB_W    = cnt_width(DEB_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [DEB_W-1:0]  r_deb_cnt;
    key_state_t        r_state;
    key_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_level   <= ~r_level;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // A falling level always wins over a long/repeat point in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        o_press     = 1'b0;
        o_release   = 1'b0;
        o_click     = 1'b0;
        o_long      = 1'b0;
        o_repeat    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level) begin
                    o_press     = 1'b1;
                    w_state_nxt = S_HELD;
                    w_hold_nxt  = '0;
                end
            end
            S_HELD: begin
                if (!r_level) begin
                    o_release   = 1'b1;
                    o_click     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end else if (r_hold == LONG_LAST) begin
                    o_long      = 1'b1;
                    w_state_nxt = S_LONG;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + 1'b1;
                end
            end
            S_LONG: begin
                if (!r_level) begin
                    o_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end else if (r_hold == REP_LAST) begin
                    o_repeat    = i_repeat_en;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign o_level = r_level;

endmodule

// File: rtl/key_event_unit.sv
// N-channel key front end: polarity fix, per-key event channels, event summary flag.
module key_event_unit
    import key_event_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 120000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2400000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_keys,
    input  logic [N_KEYS-1:0] i_repeat_en,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_click,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat,
    output logic              o_any_event
);

    logic [N_KEYS-1:0] w_pressed;
    logic              w_any_pulse;
    logic              r_any_event;

    assign w_pressed = ACTIVE_LOW ? ~i_keys : i_keys;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        key_event_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_key      (w_pressed[k]),
            .i_repeat_en(i_repeat_en[k]),
            .o_level    (o_level[k]),
            .o_press    (o_press[k]),
            .o_release  (o_release[k]),
            .o_click    (o_click[k]),
            .o_long     (o_long[k]),
            .o_repeat   (o_repeat[k])
        );
    end

    assign w_any_pulse = |{o_press, o_release, o_click, o_long, o_repeat};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_any_event <= 1'b0;
        end else begin
            r_any_event <= w_any_pulse;
        end
    end

    assign o_any_event = r_any_event;

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: timestamp-based reference model checked every cycle, plus fixed scenarios.
module tb_key_event_unit;

    localparam int NK   = 4;
    localparam int DEB  = 8;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [NK-1:0] i_keys;
    logic [NK-1:0] i_repeat_en;
    logic [NK-1:0] o_level, o_press, o_release, o_click, o_long, o_repeat;
    logic          o_any_event;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_event_unit #(
        .N_KEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_keys(i_keys), .i_repeat_en(i_repeat_en),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_click(o_click), .o_long(o_long), .o_repeat(o_repeat),
        .o_any_event(o_any_event)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pipeline delay, run-length debounce, then events derived
    // from the cycle distance to the most recent press.
    bit m_valid = 1'b0;
    int m_t     = 0;
    bit m_s1[NK], m_s2[NK], m_lvl[NK], m_prev[NK];
    int m_run[NK];
    int m_p[NK];
    bit m_any   = 1'b0;

    always @(negedge clk) begin : compare
        logic [NK-1:0] e_lvl, e_press, e_rel, e_click, e_long, e_rep;
        int held;
        e_lvl = '0; e_press = '0; e_rel = '0; e_click = '0; e_long = '0; e_rep = '0;
        for (int k = 0; k < NK; k++) begin
            held        = m_t - m_p[k];
            e_lvl[k]    = m_lvl[k];
            e_press[k]  = m_lvl[k] && !m_prev[k];
            e_rel[k]    = !m_lvl[k] && m_prev[k];
            e_click[k]  = e_rel[k] && (held <= LONG);
            e_long[k]   = m_lvl[k] && m_prev[k] && (held == LONG);
            e_rep[k]    = m_lvl[k] && m_prev[k] && (held > LONG) &&
                          ((held - LONG) % REP == 0) && i_repeat_en[k];
        end
        if (m_valid) begin
            chk("m_level",   o_level,     e_lvl);
            chk("m_press",   o_press,     e_press);
            chk("m_release", o_release,   e_rel);
            chk("m_click",   o_click,     e_click);
            chk("m_long",    o_long,      e_long);
            chk("m_repeat",  o_repeat,    e_rep);
            chk("m_any",     o_any_event, m_any);
        end
        if (i_rst) begin
            m_valid = 1'b1;
            m_any   = 1'b0;
            for (int k = 0; k < NK; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_prev[k] = 0; m_run[k] = 0;
            end
        end else if (m_valid) begin
            m_any = |{e_press, e_rel, e_click, e_long, e_rep};
            for (int k = 0; k < NK; k++) begin
                if (e_press[k]) m_p[k] = m_t;
                m_prev[k] = m_lvl[k];
                if (m_s2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_lvl[k] = !m_lvl[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = !i_keys[k];
            end
        end
        m_t++;
    end

    task automatic cyc(input logic rst, input logic [NK-1:0] keys, input logic [NK-1:0] en);
        @(posedge clk);
        #1;
        i_rst       = rst;
        i_keys      = keys;
        i_repeat_en = en;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b1, '1, '0);
        cyc(1'b1, '1, '0);
    endtask

    initial begin
        logic [NK-1:0] acc;
        int            rq[$];
        int            dur[NK];
        logic [NK-1:0] raw;
        i_rst = 1'b1; i_keys = '1; i_repeat_en = '0;

        // Reset held with keys released: everything quiet.
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, '1, '0);
            chk("rst_quiet", {o_level, o_press, o_release, o_click, o_long, o_repeat, o_any_event}, 0);
        end

        // Key0 short press: click, no long.
        do_reset();
        acc = '0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, (c <= 14) ? 4'b1110 : 4'b1111, 4'b0000);
            acc |= o_long;
            if (c == 9)  chk("k0_level_pre", o_level, 4'b0000);
            if (c == 10) chk("k0_press", o_press, 4'b0001);
            if (c == 24) chk("k0_level_hold", o_level, 4'b0001);
            if (c == 25) begin
                chk("k0_release", o_release, 4'b0001);
                chk("k0_click", o_click, 4'b0001);
                chk("k0_level_off", o_level, 4'b0000);
            end
        end
        chk("k0_no_long", acc, 4'b0000);

        // Key1 glitch shorter than the debounce window.
        do_reset();
        acc = '0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b0, (c <= 6) ? 4'b1101 : 4'b1111, 4'b0000);
            acc |= o_level | o_press;
        end
        chk("k1_glitch", acc, 4'b0000);

        // Key2 long hold with auto-repeat enabled.
        do_reset();
        rq.delete();
        for (int c = 0; c < 60; c++) begin
            cyc(1'b0, (c <= 39) ? 4'b1011 : 4'b1111, 4'b0100);
            if (o_repeat[2]) rq.push_back(c);
            if (c == 10) chk("k2_press", o_press, 4'b0100);
            if (c == 30) chk("k2_long", o_long, 4'b0100);
            if (c == 50) begin
                chk("k2_release", o_release, 4'b0100);
                chk("k2_no_click", o_click, 4'b0000);
            end
        end
        chk("k2_rep_count", rq.size(), 3);
        if (rq.size() == 3) begin
            chk("k2_rep0", rq[0], 35);
            chk("k2_rep1", rq[1], 40);
            chk("k2_rep2", rq[2], 45);
        end

        // Keys 0 and 3 together, repeat disabled.
        do_reset();
        acc = '0;
        for (int c = 0; c < 60; c++) begin
            cyc(1'b0, (c <= 39) ? 4'b0110 : 4'b1111, 4'b0000);
            acc |= o_repeat;
            if (c == 10) begin
                chk("k03_press", o_press, 4'b1001);
                chk("k03_any_10", o_any_event, 1'b0);
            end
            if (c == 11) chk("k03_any_11", o_any_event, 1'b1);
            if (c == 30) chk("k03_long", o_long, 4'b1001);
            if (c == 31) chk("k03_any_31", o_any_event, 1'b1);
            if (c == 50) chk("k03_release", o_release, 4'b1001);
        end
        chk("k03_no_repeat", acc, 4'b0000);

        // Reset in the middle of a hold: key re-detected as a new press.
        do_reset();
        acc = '0;
        for (int c = 0; c < 50; c++) begin
            cyc(c == 25, 4'b1011, 4'b0100);
            if (c == 26) chk("rh_cleared", {o_level, o_press, o_release, o_click, o_long, o_repeat, o_any_event}, 0);
            if (c >= 26 && c <= 35) acc |= o_press;
            if (c == 36) chk("rh_repress", o_press, 4'b0100);
        end
        chk("rh_no_early_press", acc, 4'b0000);

        // Randomised key activity, repeat enables and rare resets.
        do_reset();
        raw = '1;
        for (int k = 0; k < NK; k++) dur[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    raw[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12))
                                                         : int'($urandom_range(13, 60));
                end
                dur[k]--;
            end
            cyc($urandom_range(0, 299) == 0, raw, NK'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
